fc_layer_engine: RTL and testbench
==================================

# fc_layer_engine

Fully-connected layer compute engine for the digit-recognition datapath. It sits directly downstream of the FC weight ROMs (16-bit words, 512 entries, dual read port, one-cycle registered read). Each cycle it drives both ROM address ports and both ports of the activation buffer, multiplies two weight/activation pairs, and accumulates one output neuron at a time. Results stream out one neuron per `out_valid` pulse in Q8.8 format, with optional ReLU.

## Interface
Parameters:
- `N_IN`, 32: inputs per neuron. Must be even and ≥ 4.
- `N_OUT`, 16: neurons per layer. `N_IN*N_OUT` ≤ 512.
- `ACT_AW`, 5: activation address width, ≥ clog2(`N_IN`).
- `RELU`, 1: 1 clamps negative results to 0.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to compute the full layer.
- `busy` out 1: high while a layer is in progress.
- `w_addr_a`, `w_addr_b` out 9: weight ROM addresses.
- `w_q_a`, `w_q_b` in 16: weight ROM data, valid one cycle after the address, signed Q8.8.
- `act_addr_a`, `act_addr_b` out `ACT_AW`: activation buffer addresses.
- `act_q_a`, `act_q_b` in 16: activation data, one-cycle registered read, signed Q8.8.
- `out_valid` out 1: one-cycle pulse per finished neuron.
- `out_index` out 8: neuron number of the current result.
- `out_data` out 16: signed Q8.8 result.
- `done` out 1: one-cycle pulse on the last neuron's `out_valid` cycle.

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN.
  - RUN: issue one address pair per cycle. After the last pair of the last neuron, go to DRAIN.
  - DRAIN: wait for the pipeline to empty. Return to IDLE in the cycle `done` is asserted.
- `start` is ignored outside IDLE.
- Address sequence for neuron j, pair k (k = 0 .. `N_IN`/2−1):
  - `w_addr_a` = j·`N_IN` + 2k, `w_addr_b` = j·`N_IN` + 2k + 1.
  - `act_addr_a` = 2k, `act_addr_b` = 2k + 1.
- Neurons are issued back to back with no bubbles.
- Pipeline, with first/last/index tags carried alongside the data:
  - S0: address issue.
  - S1: memory data returns. Two signed 16×16 products are registered as 32-bit values.
  - S2: sum = p_a + p_b (33-bit). On a first-pair tag the accumulator is loaded with the sum; otherwise the sum is added to it. Accumulator is 40-bit signed.
  - S3: on a last-pair tag, produce the output registers.
- Output conversion:
  - Arithmetic shift right of the accumulator by 8, truncating toward −∞.
  - Saturate to [−32768, 32767].
  - If `RELU`=1, replace negative values with 0.
- Outside RUN, addresses hold their last value. No memory enables are driven; the memories are always-read.
- Reset (asynchronous, any time including mid-layer):
  - State returns to IDLE. Accumulator, tags and pipeline valids clear.
  - All outputs go to 0: `busy`, `out_valid`, `done`, `out_index`, `out_data`, all addresses.
  - No partial result is emitted after reset deasserts.

## Timing
- `start` is sampled high at edge 0.
- `busy` rises at edge 0 and falls at the edge after `done`.
- The first address pair is driven during cycle 1, after edge 0.
- Per-neuron issue time: P = `N_IN`/2 cycles. Default P = 16.
- Latency: neuron j's last pair is issued in cycle (j+1)·P. Its `out_valid` is high in cycle (j+1)·P + 3.
- Throughput: one result every P cycles, continuing through the whole layer.
- `done` coincides with `out_valid` for neuron `N_OUT`−1. Default: cycle 259.
- `out_index`/`out_data` hold their value between pulses. They update only on an `out_valid` cycle.
- A `start` in the same cycle as `done` is ignored, since the FSM is not yet in IDLE. A new layer may start from the following cycle.

## Test plan
- All weights 0x0100, all activations 0x0100, defaults → 16 `out_valid` pulses with `out_data` = 0x2000 and `out_index` 0..15 at cycles 19, 35, …, 259. `done` at cycle 259; `busy` low from cycle 260.
- Weight address = value in Q8.8 integer (w[i] = i<<8 mod 2^16 as signed), activations 0x0100 → each neuron's result matches a reference sum. Also check every issued address sequence against the formula.
- All weights 0x7FFF, activations 0x7FFF → 0x7FFF, saturated high. Weights 0x8000, activations 0x7FFF: with `RELU`=0 → 0x8000; with `RELU`=1 → 0x0000.
- Mixed signs where the exact sum is −0.5 LSB (accumulator = −128) → `out_data` 0xFFFF with `RELU`=0 (floor rounding).
- `start` pulsed at cycles 5, 100, and 259 during a layer → no restart; pulse count stays 16. `start` at cycle 260 → a second layer runs with identical results.
- `reset_n` low at cycle 50 for 3 cycles → all outputs 0 asynchronously, `busy` low, no `out_valid` afterwards. A later `start` produces a full, correct layer.

Source files
------------

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully-connected layer engine. Streams two weight/activation
// pairs per cycle from always-read memories, accumulates one neuron at a time
// and emits each neuron as a saturated Q8.8 value with optional ReLU.
`timescale 1ns/1ps

module fc_layer_engine #(
    parameter int N_IN   = 32,
    parameter int N_OUT  = 16,
    parameter int ACT_AW = 5,
    parameter int RELU   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic [8:0]        w_addr_a,
    output logic [8:0]        w_addr_b,
    input  logic [15:0]       w_q_a,
    input  logic [15:0]       w_q_b,
    output logic [ACT_AW-1:0] act_addr_a,
    output logic [ACT_AW-1:0] act_addr_b,
    input  logic [15:0]       act_q_a,
    input  logic [15:0]       act_q_b,
    output logic              out_valid,
    output logic [7:0]        out_index,
    output logic [15:0]       out_data,
    output logic              done
);

    localparam int P  = N_IN / 2;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Issue counters and address registers (stage S0)
    logic [PW-1:0]     pair_reg;
    logic [7:0]        neuron_reg;
    logic [8:0]        w_addr_a_reg, w_addr_b_reg;
    logic [ACT_AW-1:0] act_addr_a_reg, act_addr_b_reg;
    logic              last_pair, last_neuron, issue;

    // Stage S1 tags (memory data returning)
    logic       s1_valid_reg, s1_first_reg, s1_last_reg;
    logic [7:0] s1_index_reg;

    // Stage S2 tags (products registered)
    logic       s2_valid_reg, s2_first_reg, s2_last_reg;
    logic [7:0] s2_index_reg;

    // Accumulator and output registers
    logic signed [39:0] acc_reg, acc_next;
    logic signed [32:0] sum_comb;
    logic signed [39:0] sum_ext, shifted;
    logic [15:0]        sat_val, result;
    logic               out_valid_reg, done_reg;
    logic [7:0]         out_index_reg;
    logic [15:0]        out_data_reg;

    logic [1:0][15:0]   w_lane, a_lane;
    logic signed [31:0] prod_a, prod_b;

    assign last_pair   = (pair_reg == PW'(P - 1));
    assign last_neuron = (neuron_reg == 8'(N_OUT - 1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an address pair is live whenever the FSM sits in RUN
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last_pair && last_neuron) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the final result is on the outputs
                if (done_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address generation: weights are contiguous across neurons, so the weight
    // pair simply steps by two; activations wrap to the start every neuron.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pair_reg       <= '0;
            neuron_reg     <= '0;
            w_addr_a_reg   <= '0;
            w_addr_b_reg   <= '0;
            act_addr_a_reg <= '0;
            act_addr_b_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            pair_reg       <= '0;
            neuron_reg     <= '0;
            w_addr_a_reg   <= 9'd0;
            w_addr_b_reg   <= 9'd1;
            act_addr_a_reg <= ACT_AW'(0);
            act_addr_b_reg <= ACT_AW'(1);
        end else if (state_reg == RUN && !(last_pair && last_neuron)) begin
            w_addr_a_reg <= w_addr_a_reg + 9'd2;
            w_addr_b_reg <= w_addr_b_reg + 9'd2;
            if (last_pair) begin
                pair_reg       <= '0;
                neuron_reg     <= neuron_reg + 8'd1;
                act_addr_a_reg <= ACT_AW'(0);
                act_addr_b_reg <= ACT_AW'(1);
            end else begin
                pair_reg       <= pair_reg + PW'(1);
                act_addr_a_reg <= act_addr_a_reg + ACT_AW'(2);
                act_addr_b_reg <= act_addr_b_reg + ACT_AW'(2);
            end
        end
    end

    // Tags follow the address pair into the cycle its memory data returns
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_index_reg <= '0;
        end else begin
            s1_valid_reg <= issue;
            s1_first_reg <= issue && (pair_reg == '0);
            s1_last_reg  <= issue && last_pair;
            s1_index_reg <= neuron_reg;
        end
    end

    assign w_lane = {w_q_b, w_q_a};
    assign a_lane = {act_q_b, act_q_a};

    // One signed multiplier per memory port, product registered in S1
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [31:0] prod_reg;

        // Register the Q16.16 product of this lane
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                prod_reg <= '0;
            end else begin
                prod_reg <= $signed(w_lane[gi]) * $signed(a_lane[gi]);
            end
        end
    end

    assign prod_a = g_lane[0].prod_reg;
    assign prod_b = g_lane[1].prod_reg;

    // Tags move alongside the registered products
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_reg <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_index_reg <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
            s2_index_reg <= s1_index_reg;
        end
    end

    // Pair sum, accumulate, and Q8.8 conversion (floor shift, saturate, ReLU)
    always_comb begin
        sum_comb = {prod_a[31], prod_a} + {prod_b[31], prod_b};
        sum_ext  = {{7{sum_comb[32]}}, sum_comb};
        acc_next = s2_first_reg ? sum_ext : (acc_reg + sum_ext);
        shifted  = acc_next >>> 8;
        if (shifted > 40'sd32767) begin
            sat_val = 16'h7FFF;
        end else if (shifted < -40'sd32768) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = shifted[15:0];
        end
        if (RELU != 0 && sat_val[15]) begin
            result = 16'h0000;
        end else begin
            result = sat_val;
        end
    end

    // Accumulator only moves on valid pairs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else if (s2_valid_reg) begin
            acc_reg <= acc_next;
        end
    end

    // Output registers: index/data hold between pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            out_index_reg <= '0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= s2_valid_reg && s2_last_reg;
            done_reg      <= s2_valid_reg && s2_last_reg &&
                             (s2_index_reg == 8'(N_OUT - 1));
            if (s2_valid_reg && s2_last_reg) begin
                out_index_reg <= s2_index_reg;
                out_data_reg  <= result;
            end
        end
    end

    assign busy       = (state_reg != IDLE);
    assign w_addr_a   = w_addr_a_reg;
    assign w_addr_b   = w_addr_b_reg;
    assign act_addr_a = act_addr_a_reg;
    assign act_addr_b = act_addr_b_reg;
    assign out_valid  = out_valid_reg;
    assign out_index  = out_index_reg;
    assign out_data   = out_data_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: two engines (RELU=0 and RELU=1) run the same layers side
// by side; expected neurons are queued at start and a monitor checks them.
`timescale 1ns/1ps

module tb_fc_layer_engine;

    localparam int N_IN      = 32;
    localparam int N_OUT     = 16;
    localparam int ACT_AW    = 5;
    localparam int P         = N_IN / 2;
    localparam int LAYER_CYC = N_OUT * P + 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;

    always #5 clock = ~clock;

    logic [1:0]              busy_s, out_valid_s, done_s;
    logic [1:0][8:0]         w_addr_a_s, w_addr_b_s;
    logic [1:0][15:0]        w_q_a_s, w_q_b_s, act_q_a_s, act_q_b_s, out_data_s;
    logic [1:0][ACT_AW-1:0]  act_addr_a_s, act_addr_b_s;
    logic [1:0][7:0]         out_index_s;

    logic [15:0] rom [512];
    logic [15:0] act_mem [1 << ACT_AW];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fc_layer_engine #(
            .N_IN(N_IN), .N_OUT(N_OUT), .ACT_AW(ACT_AW), .RELU(gi)
        ) u_dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .start      (start),
            .busy       (busy_s[gi]),
            .w_addr_a   (w_addr_a_s[gi]),
            .w_addr_b   (w_addr_b_s[gi]),
            .w_q_a      (w_q_a_s[gi]),
            .w_q_b      (w_q_b_s[gi]),
            .act_addr_a (act_addr_a_s[gi]),
            .act_addr_b (act_addr_b_s[gi]),
            .act_q_a    (act_q_a_s[gi]),
            .act_q_b    (act_q_b_s[gi]),
            .out_valid  (out_valid_s[gi]),
            .out_index  (out_index_s[gi]),
            .out_data   (out_data_s[gi]),
            .done       (done_s[gi])
        );
    end

    // Registered-read memories, one read path per engine
    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            w_q_a_s[u]   <= rom[w_addr_a_s[u]];
            w_q_b_s[u]   <= rom[w_addr_b_s[u]];
            act_q_a_s[u] <= act_mem[act_addr_a_s[u]];
            act_q_b_s[u] <= act_mem[act_addr_b_s[u]];
        end
    end

    longint edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
        bit          last;
        longint      cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input int inst,
                       input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h required %0h", name, inst, got, want);
        end
    endtask

    // Reference: exact dot product, floor(sum/256), clamp, optional ReLU
    function automatic logic [15:0] ref_out(input int j, input bit relu);
        longint s;
        longint fl;
        s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += longint'($signed(rom[j * N_IN + i])) * longint'($signed(act_mem[i]));
        end
        fl = (s - (((s % 256) + 256) % 256)) / 256;
        if (fl > 32767) fl = 32767;
        if (fl < -32768) fl = -32768;
        if (relu && fl < 0) fl = 0;
        return fl[15:0];
    endfunction

    task automatic push_expected(input longint x0);
        exp_t e;
        for (int j = 0; j < N_OUT; j++) begin
            e.idx  = j;
            e.last = (j == N_OUT - 1);
            e.cyc  = x0 + longint'((j + 1) * P + 2);
            e.data = ref_out(j, 1'b0);
            q0.push_back(e);
            e.data = ref_out(j, 1'b1);
            q1.push_back(e);
        end
    endtask

    // Monitor: every out_valid pops one expected neuron
    exp_t mon_e;
    bit   mon_empty;
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (out_valid_s[u]) begin
                mon_empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (mon_empty) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid inst%0d: got index %0d data %h, required no pulse",
                             u, out_index_s[u], out_data_s[u]);
                end else begin
                    if (u == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    chk("out_index", u, 64'(out_index_s[u]), 64'(mon_e.idx));
                    chk("out_data",  u, 64'(out_data_s[u]),  64'(mon_e.data));
                    chk("done_flag", u, 64'(done_s[u]),      64'(mon_e.last));
                    chk("out_cycle", u, 64'(edge_cnt),       64'(mon_e.cyc));
                end
            end else if (done_s[u]) begin
                checks++;
                errors++;
                $display("FAIL done_without_valid inst%0d: got done=1 required 0", u);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        for (int u = 0; u < 2; u++) begin
            chk(name, u,
                64'({busy_s[u], out_valid_s[u], done_s[u], out_index_s[u], out_data_s[u],
                     w_addr_a_s[u], w_addr_b_s[u], act_addr_a_s[u], act_addr_b_s[u]}),
                64'(0));
        end
    endtask

    // One full layer from the current negedge; optional stray start pulses
    task automatic run_layer(input bit poke);
        int j, k;
        push_expected(edge_cnt + 1);
        start = 1'b1;
        for (int n = 1; n <= LAYER_CYC + 1; n++) begin
            @(negedge clock);
            start = poke && (n == 5 || n == 100 || n == LAYER_CYC);
            if (n <= N_OUT * P) begin
                j = (n - 1) / P;
                k = (n - 1) % P;
                for (int u = 0; u < 2; u++) begin
                    chk("addr_seq", u,
                        64'({w_addr_a_s[u], w_addr_b_s[u], act_addr_a_s[u], act_addr_b_s[u]}),
                        64'({9'(j * N_IN + 2 * k), 9'(j * N_IN + 2 * k + 1),
                             ACT_AW'(2 * k), ACT_AW'(2 * k + 1)}));
                end
            end
            if (n == 1 || n == LAYER_CYC) begin
                for (int u = 0; u < 2; u++) chk("busy_high", u, 64'(busy_s[u]), 64'(1));
            end
            if (n == LAYER_CYC + 1) begin
                for (int u = 0; u < 2; u++) chk("busy_low", u, 64'(busy_s[u]), 64'(0));
            end
        end
        start = 1'b0;
    endtask

    task automatic fill(input int mode);
        logic signed [9:0] t;
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0: rom[i] = 16'h0100;
                1: rom[i] = 16'(i << 8);
                2: rom[i] = 16'h7FFF;
                3: rom[i] = 16'h8000;
                4: rom[i] = 16'h0000;
                5: rom[i] = 16'($urandom);
                default: begin
                    t = 10'($urandom);
                    rom[i] = {{6{t[9]}}, t};
                end
            endcase
        end
        for (int i = 0; i < (1 << ACT_AW); i++) begin
            case (mode)
                2, 3:    act_mem[i] = 16'h7FFF;
                4:       act_mem[i] = 16'h0000;
                5:       act_mem[i] = 16'($urandom);
                6: begin
                    t = 10'($urandom);
                    act_mem[i] = {{6{t[9]}}, t};
                end
                default: act_mem[i] = 16'h0100;
            endcase
        end
        if (mode == 4) begin
            // Every neuron sums to -128: exactly -0.5 LSB in Q8.8
            act_mem[0] = 16'h0001;
            act_mem[1] = 16'h0002;
            act_mem[2] = 16'h0004;
            act_mem[3] = 16'h0002;
            for (int j = 0; j < N_OUT; j++) begin
                rom[j * N_IN + 0] = 16'hFF80;
                rom[j * N_IN + 1] = 16'h0040;
                rom[j * N_IN + 2] = 16'hFFC0;
                rom[j * N_IN + 3] = 16'h0040;
            end
        end
    endtask

    initial begin
        fill(0);
        repeat (3) @(negedge clock);
        chk_all_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        fill(0); run_layer(1'b0); @(negedge clock);
        fill(1); run_layer(1'b0); @(negedge clock);
        fill(2); run_layer(1'b0); @(negedge clock);
        fill(3); run_layer(1'b0); @(negedge clock);
        fill(4); run_layer(1'b0); @(negedge clock);
        fill(5); run_layer(1'b0); @(negedge clock);
        fill(5); run_layer(1'b0); @(negedge clock);
        fill(6); run_layer(1'b0); @(negedge clock);

        // Stray starts mid-layer and on the done cycle, then back-to-back layer
        fill(6);
        run_layer(1'b1);
        run_layer(1'b0);
        @(negedge clock);

        // Asynchronous reset in the middle of a layer
        fill(5);
        push_expected(edge_cnt + 1);
        start = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clock);
            start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        for (int u = 0; u < 2; u++) chk("busy_after_reset", u, 64'(busy_s[u]), 64'(0));

        fill(6); run_layer(1'b0);
        repeat (5) @(negedge clock);

        chk("queue_left", 0, 64'(q0.size()), 64'(0));
        chk("queue_left", 1, 64'(q1.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
